// File: rtl/shared_adder_arbiter.sv
// Four requesters share one ripple-carry adder through a round-robin grant.
// Results are held in a single output register.
module shared_adder_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req_valid,
    input  logic [4*WIDTH-1:0]   req_a,
    input  logic [4*WIDTH-1:0]   req_b,
    output logic [3:0]           req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [1:0]           resp_id,
    output logic [WIDTH-1:0]     resp_sum,
    output logic                 resp_carry,
    output logic [15:0]          op_count
);

    logic             r_resp_valid;
    logic [1:0]       r_resp_id;
    logic [WIDTH-1:0] r_resp_sum;
    logic             r_resp_carry;
    logic [1:0]       r_rr_ptr;
    logic [15:0]      r_op_count;

    logic             w_slot_free;
    logic             w_found;
    logic [1:0]       w_idx;
    logic [1:0]       w_gnt_idx;
    logic [3:0]       w_grant;
    logic             w_accept;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_sum;
    logic             w_ripple_c;
    logic             w_carry;

    assign w_slot_free = !r_resp_valid || resp_ready;

    // Round-robin search starting at r_rr_ptr; operands never influence the grant.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = 2'd0;
        w_idx     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_rr_ptr + 2'(k);
            if (!w_found && req_valid[w_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
        w_grant = w_found ? (4'b0001 << w_gnt_idx) : 4'b0000;
    end

    assign req_ready = (!rst && w_slot_free) ? w_grant : 4'b0000;
    assign w_accept  = |req_ready;

    assign w_op_a = req_a[w_gnt_idx*WIDTH +: WIDTH];
    assign w_op_b = req_b[w_gnt_idx*WIDTH +: WIDTH];

    always_comb begin
        w_ripple_c = 1'b0;
        w_sum      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum[i]   = w_op_a[i] ^ w_op_b[i] ^ w_ripple_c;
            w_ripple_c = (w_op_a[i] & w_op_b[i]) | (w_ripple_c & (w_op_a[i] ^ w_op_b[i]));
        end
        w_carry = w_ripple_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= 2'd0;
            r_resp_sum   <= '0;
            r_resp_carry <= 1'b0;
            r_rr_ptr     <= 2'd0;
            r_op_count   <= 16'd0;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_resp_id    <= w_gnt_idx;
            r_resp_sum   <= w_sum;
            r_resp_carry <= w_carry;
            r_rr_ptr     <= w_gnt_idx + 2'd1;
            r_op_count   <= r_op_count + 16'd1;
        end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_sum   = r_resp_sum;
    assign resp_carry = r_resp_carry;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed bench for shared_adder_arbiter: vector table plus hand-written
// back-pressure, reset and counter-wrap sequences.
module tb_shared_adder_arbiter;

    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic [3:0]     req_valid;
    logic [4*W-1:0] req_a;
    logic [4*W-1:0] req_b;
    logic [3:0]     req_ready;
    logic           resp_valid;
    logic           resp_ready;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_sum;
    logic           resp_carry;
    logic [15:0]    op_count;

    int n_checks = 0;
    int n_fail   = 0;

    shared_adder_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_carry (resp_carry),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]     valid;
        logic [4*W-1:0] a;
        logic [4*W-1:0] b;
        logic [3:0]     exp_ready;
        logic           exp_rvalid;
        logic [1:0]     exp_id;
        logic [W-1:0]   exp_sum;
        logic           exp_carry;
    } vec_t;

    vec_t vec [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = 4'b0000;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [W-1:0] exp_s;

    initial begin
        // grant pointer walks 0 -> 1 -> 3 -> 1 -> 0 -> 0 -> 2 -> 3 -> 0
        vec[0] = '{4'b0001, {32'd0, 32'd0, 32'd0, 32'd5}, {32'd0, 32'd0, 32'd0, 32'd7},
                   4'b0001, 1'b1, 2'd0, 32'd12, 1'b0};
        vec[1] = '{4'b0100, {32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0}, {32'd0, 32'd1, 32'd0, 32'd0},
                   4'b0100, 1'b1, 2'd2, 32'd0, 1'b1};
        vec[2] = '{4'b0011, {32'd0, 32'd0, 32'd10, 32'd1}, {32'd0, 32'd0, 32'd20, 32'd2},
                   4'b0001, 1'b1, 2'd0, 32'd3, 1'b0};
        vec[3] = '{4'b1001, {32'h8000_0000, 32'd0, 32'd0, 32'd99}, {32'h8000_0000, 32'd0, 32'd0, 32'd1},
                   4'b1000, 1'b1, 2'd3, 32'd0, 1'b1};
        vec[4] = '{4'b0000, {32'd1, 32'd1, 32'd1, 32'd1}, {32'd1, 32'd1, 32'd1, 32'd1},
                   4'b0000, 1'b0, 2'd0, 32'd0, 1'b0};
        vec[5] = '{4'b0110, {32'd0, 32'd5, 32'h1234_5678, 32'd0}, {32'd0, 32'd5, 32'h1111_1111, 32'd0},
                   4'b0010, 1'b1, 2'd1, 32'h2345_6789, 1'b0};
        vec[6] = '{4'b0110, {32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0}, {32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0},
                   4'b0100, 1'b1, 2'd2, 32'hFFFF_FFFE, 1'b1};
        vec[7] = '{4'b1111, {32'hA, 32'd1, 32'd1, 32'd1}, {32'h5, 32'd1, 32'd1, 32'd1},
                   4'b1000, 1'b1, 2'd3, 32'hF, 1'b0};

        req_a = '0;
        req_b = '0;

        // reset state, with requests present while rst is high
        rst        = 1'b1;
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_resp_valid", 64'(resp_valid), 64'h0);
        check("rst_resp_id", 64'(resp_id), 64'h0);
        check("rst_resp_sum", 64'(resp_sum), 64'h0);
        check("rst_resp_carry", 64'(resp_carry), 64'h0);
        check("rst_op_count", 64'(op_count), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            req_valid  = vec[i].valid;
            req_a      = vec[i].a;
            req_b      = vec[i].b;
            resp_ready = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(vec[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rvalid", i), 64'(resp_valid), 64'(vec[i].exp_rvalid));
            if (vec[i].exp_rvalid) begin
                check($sformatf("vec%0d_id", i), 64'(resp_id), 64'(vec[i].exp_id));
                check($sformatf("vec%0d_sum", i), 64'(resp_sum), 64'(vec[i].exp_sum));
                check($sformatf("vec%0d_carry", i), 64'(resp_carry), 64'(vec[i].exp_carry));
            end
        end
        check("vec_op_count", 64'(op_count), 64'd7);

        // all four requesting, consumer always ready: strict rotation at full rate
        do_reset();
        req_a      = {32'd49, 32'd33, 32'd17, 32'd1};
        req_b      = {32'd1000, 32'd1000, 32'd1000, 32'd1000};
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("rr%0d_ready", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
            @(posedge clk);
            #1;
            exp_s = 32'(1 + 16 * (k % 4) + 1000);
            check($sformatf("rr%0d_rvalid", k), 64'(resp_valid), 64'h1);
            check($sformatf("rr%0d_id", k), 64'(resp_id), 64'(k % 4));
            check($sformatf("rr%0d_sum", k), 64'(resp_sum), 64'(exp_s));
        end
        check("rr_op_count", 64'(op_count), 64'd8);

        // consumer stalls: no grant, result held stable, operands wiggling
        req_valid  = 4'b0010;
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_a = {4{32'(32'h55 + k)}};
            @(negedge clk);
            check($sformatf("stall%0d_ready", k), 64'(req_ready), 64'h0);
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_rvalid", k), 64'(resp_valid), 64'h1);
            check($sformatf("stall%0d_id", k), 64'(resp_id), 64'd3);
            check($sformatf("stall%0d_sum", k), 64'(resp_sum), 64'd1049);
        end
        req_a      = {4{32'h55}};
        resp_ready = 1'b1;
        @(negedge clk);
        check("release_ready", 64'(req_ready), 64'b0010);
        @(posedge clk);
        #1;
        check("release_rvalid", 64'(resp_valid), 64'h1);
        check("release_id", 64'(resp_id), 64'd1);
        check("release_sum", 64'(resp_sum), 64'd1085);
        check("release_op_count", 64'(op_count), 64'd9);

        // operands changing after the accept edge must not disturb the result
        req_valid  = 4'b0000;
        resp_ready = 1'b0;
        req_a      = '1;
        req_b      = '1;
        @(posedge clk);
        #1;
        check("hold_sum", 64'(resp_sum), 64'd1085);
        check("hold_carry", 64'(resp_carry), 64'h0);

        // retire with nothing new clears the slot
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("retire_rvalid", 64'(resp_valid), 64'h0);

        // reset in the middle of operation with a pending result
        do_reset();
        req_a      = {32'd0, 32'd0, 32'd0, 32'd4};
        req_b      = {32'd0, 32'd0, 32'd0, 32'd4};
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_op_count", 64'(op_count), 64'd5);
        check("pre_rst_rvalid", 64'(resp_valid), 64'h1);
        rst        = 1'b1;
        req_valid  = 4'b1111;
        resp_ready = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 64'(req_ready), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_rvalid", 64'(resp_valid), 64'h0);
        check("post_rst_op_count", 64'(op_count), 64'h0);
        @(negedge clk);
        check("post_rst_ready", 64'(req_ready), 64'b0001);

        // operation counter wraps
        do_reset();
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        check("op_count_max", 64'(op_count), 64'hFFFF);
        @(posedge clk);
        #1;
        check("op_count_wrap", 64'(op_count), 64'h0);
        req_valid = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
